// File: rtl/uart_rx_deserializer.sv
// Receive half of the Avalon-MM UART: synchroniser, bit timer and frame deserialiser.
// Optional build macro UART_RX_MAJORITY_EN enables a 2-of-3 vote on every bit sample.
module uart_rx_deserializer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIVISOR = 4
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic        coe_conduit_rx,
  input  logic [31:0] clockDivisor,
  input  logic [2:0]  dataBits,
  input  logic [1:0]  parityBit,
  input  logic        stopBits2,
  input  logic        rxAck,
  output logic [8:0]  rxData,
  output logic        rxFull,
  output logic        frameError,
  output logic        parityError,
  output logic        rxOverRun,
  output logic        rxBusy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, COMMIT, BREAK
  } rxState_t;

  localparam logic [31:0] MinDiv = MIN_DIVISOR;

  rxState_t state, nextState;

  logic [SYNC_STAGES-1:0] syncReg;
  logic        rxs;
  logic        rxsPrev;
  logic        startEdge;
  logic        sampleTick;
  logic        sampleBit;
  logic        timerActive;

  logic [31:0] effDiv;
  logic [31:0] divLatched;
  logic [31:0] bitTimer;
  logic [2:0]  dataBitsClamped;
  logic [3:0]  lastBitIdx;
  logic [3:0]  bitIndex;
  logic        parityEn;
  logic        parityOdd;
  logic        stop2Latched;
  logic [8:0]  shiftReg;
  logic        frameErrAcc;
  logic        parityErrAcc;

  // The synchroniser idles at 1 so that leaving reset never looks like a start edge.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      syncReg <= '1;
      rxsPrev <= 1'b1;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], coe_conduit_rx};
      rxsPrev <= rxs;
    end
  end

  assign rxs       = syncReg[SYNC_STAGES-1];
  assign startEdge = rxsPrev & ~rxs;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rxsHist;

  // Two clocks of history give a vote over the last three clocks of the bit window.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      rxsHist <= 2'b11;
    end else begin
      rxsHist <= {rxsHist[0], rxs};
    end
  end

  assign sampleBit = (rxsHist[1] & rxsHist[0]) | (rxsHist[1] & rxs) | (rxsHist[0] & rxs);
`else
  assign sampleBit = rxs;
`endif

  assign effDiv          = (clockDivisor < MinDiv) ? MinDiv : clockDivisor;
  assign dataBitsClamped = (dataBits > 3'd4) ? 3'd4 : dataBits;

  assign timerActive = (state == START) || (state == DATA) || (state == PARITY) ||
                       (state == STOP1) || (state == STOP2);
  assign sampleTick  = timerActive && (bitTimer == 32'd0);

  assign rxBusy = (state == DATA) || (state == PARITY) || (state == STOP1) ||
                  (state == STOP2) || (state == COMMIT);

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A commit with a bad stop bit parks in BREAK so a held-low line yields a single word.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startEdge) nextState = START;
      START:   if (sampleTick) nextState = sampleBit ? IDLE : DATA;
      DATA:    if (sampleTick && (bitIndex == lastBitIdx)) nextState = parityEn ? PARITY : STOP1;
      PARITY:  if (sampleTick) nextState = STOP1;
      STOP1:   if (sampleTick) nextState = stop2Latched ? STOP2 : COMMIT;
      STOP2:   if (sampleTick) nextState = COMMIT;
      COMMIT:  nextState = frameErrAcc ? BREAK : IDLE;
      BREAK:   if (rxs) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Configuration is captured on the start edge so register writes mid-frame cannot disturb it.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      bitTimer     <= '0;
      divLatched   <= '0;
      lastBitIdx   <= '0;
      bitIndex     <= '0;
      parityEn     <= 1'b0;
      parityOdd    <= 1'b0;
      stop2Latched <= 1'b0;
      shiftReg     <= '0;
      frameErrAcc  <= 1'b0;
      parityErrAcc <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (startEdge) begin
          bitTimer     <= (effDiv >> 1) - 32'd1;
          divLatched   <= effDiv;
          lastBitIdx   <= 4'd4 + {1'b0, dataBitsClamped};
          bitIndex     <= '0;
          parityEn     <= (parityBit == 2'd1) || (parityBit == 2'd2);
          parityOdd    <= (parityBit == 2'd1);
          stop2Latched <= stopBits2;
          shiftReg     <= '0;
          frameErrAcc  <= 1'b0;
          parityErrAcc <= 1'b0;
        end
      end else if (sampleTick) begin
        bitTimer <= divLatched - 32'd1;
      end else if (bitTimer != 32'd0) begin
        bitTimer <= bitTimer - 32'd1;
      end

      if (sampleTick) begin
        case (state)
          DATA: begin
            shiftReg[bitIndex] <= sampleBit;
            bitIndex           <= bitIndex + 4'd1;
          end
          PARITY: begin
            parityErrAcc <= parityOdd ? ~(^shiftReg ^ sampleBit) : (^shiftReg ^ sampleBit);
          end
          STOP1, STOP2: begin
            if (!sampleBit) frameErrAcc <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // A commit takes priority over an acknowledge arriving in the same clock.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      rxData      <= '0;
      rxFull      <= 1'b0;
      frameError  <= 1'b0;
      parityError <= 1'b0;
      rxOverRun   <= 1'b0;
    end else if (state == COMMIT) begin
      rxData      <= shiftReg;
      rxFull      <= 1'b1;
      frameError  <= frameErrAcc;
      parityError <= parityErrAcc;
      if (rxFull && !rxAck) rxOverRun <= 1'b1;
    end else if (rxAck) begin
      rxFull      <= 1'b0;
      frameError  <= 1'b0;
      parityError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus randomized frames
// compared against a bit-level reference model of the serial frame format.
module tb_uart_rx_deserializer;

  logic        csi_clk = 1'b0;
  logic        rsi_reset;
  logic        coe_conduit_rx;
  logic [31:0] clockDivisor;
  logic [2:0]  dataBits;
  logic [1:0]  parityBit;
  logic        stopBits2;
  logic        rxAck;
  logic [8:0]  rxData;
  logic        rxFull;
  logic        frameError;
  logic        parityError;
  logic        rxOverRun;
  logic        rxBusy;

  int checkCount = 0;
  int passCount  = 0;

  uart_rx_deserializer dut (
    .csi_clk        (csi_clk),
    .rsi_reset      (rsi_reset),
    .coe_conduit_rx (coe_conduit_rx),
    .clockDivisor   (clockDivisor),
    .dataBits       (dataBits),
    .parityBit      (parityBit),
    .stopBits2      (stopBits2),
    .rxAck          (rxAck),
    .rxData         (rxData),
    .rxFull         (rxFull),
    .frameError     (frameError),
    .parityError    (parityError),
    .rxOverRun      (rxOverRun),
    .rxBusy         (rxBusy)
  );

  always #5 csi_clk = ~csi_clk;

  // Parity bit that makes the frame correct for the given mode (1 odd, 2 even).
  function automatic logic goodParity(input logic [8:0] data, input int nb, input int mode);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(data[i]);
    if (mode == 2) return logic'(ones % 2);
    return logic'(1 - (ones % 2));
  endfunction

  // Reference model: what the receiver must report for one transmitted frame.
  function automatic void modelFrame(input logic [8:0] data, input int nb, input int mode,
                                     input logic pbit, input logic stopA, input logic stopB,
                                     input logic twoStops, output logic [8:0] expData,
                                     output logic expPar, output logic expFrame);
    int ones = 0;
    expData = '0;
    for (int i = 0; i < nb; i++) begin
      expData[i] = data[i];
      ones += int'(data[i]);
    end
    if (mode == 2)      expPar = ((ones + int'(pbit)) % 2) == 1;
    else if (mode == 1) expPar = ((ones + int'(pbit)) % 2) == 0;
    else                expPar = 1'b0;
    expFrame = !stopA || (twoStops && !stopB);
  endfunction

  task automatic sendFrame(input logic [8:0] data, input int nb, input logic hasPar,
                           input logic pbit, input logic stopA, input logic stopB,
                           input logic twoStops, input int bitClocks, input int tailIdle);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(data[i]);
    if (hasPar) bits.push_back(pbit);
    bits.push_back(stopA);
    if (twoStops) bits.push_back(stopB);
    foreach (bits[k]) begin
      coe_conduit_rx = bits[k];
      repeat (bitClocks) @(negedge csi_clk);
    end
    coe_conduit_rx = 1'b1;
    repeat (tailIdle) @(negedge csi_clk);
  endtask

  task automatic ackPulse();
    rxAck = 1'b1;
    @(negedge csi_clk);
    rxAck = 1'b0;
    @(negedge csi_clk);
  endtask

  task automatic test_reset();
    rsi_reset = 1'b1;
    repeat (3) @(negedge csi_clk);
    checkCount++;
    if ({rxData, rxFull, frameError, parityError, rxOverRun, rxBusy} !== 14'h0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {rxData, rxFull, frameError, parityError, rxOverRun, rxBusy});
    else passCount++;
    rsi_reset = 1'b0;
    repeat (4) @(negedge csi_clk);
  endtask

  task automatic test_basic();
    int cnt = 0;
    clockDivisor = 16; dataBits = 3; parityBit = 0; stopBits2 = 0;
    fork
      sendFrame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 40);
      while (!rxFull && cnt < 400) begin
        @(negedge csi_clk);
        cnt++;
      end
    join
    checkCount++;
    if (cnt < 148 || cnt > 164) $display("[TB] FAIL basic_latency: got %0d clocks expected 148..164", cnt);
    else passCount++;
    checkCount++;
    if (rxData !== 9'h0A5) $display("[TB] FAIL basic_data: got %h expected 0a5", rxData);
    else passCount++;
    checkCount++;
    if ({rxFull, frameError, parityError} !== 3'b100)
      $display("[TB] FAIL basic_flags: got %b expected 100", {rxFull, frameError, parityError});
    else passCount++;
    ackPulse();
    checkCount++;
    if (rxFull !== 1'b0 || rxData !== 9'h0A5)
      $display("[TB] FAIL basic_ack: got full=%b data=%h expected full=0 data=0a5", rxFull, rxData);
    else passCount++;
  endtask

  task automatic test_parity();
    logic pb;
    clockDivisor = 16; dataBits = 4; parityBit = 2; stopBits2 = 1;
    pb = goodParity(9'h1C3, 9, 2);
    sendFrame(9'h1C3, 9, 1'b1, pb, 1'b1, 1'b1, 1'b1, 16, 40);
    checkCount++;
    if (rxData !== 9'h1C3 || parityError !== 1'b0 || rxFull !== 1'b1)
      $display("[TB] FAIL parity_good: got data=%h perr=%b full=%b expected 1c3/0/1",
               rxData, parityError, rxFull);
    else passCount++;
    ackPulse();
    sendFrame(9'h1C3, 9, 1'b1, ~pb, 1'b1, 1'b1, 1'b1, 16, 40);
    checkCount++;
    if (rxData !== 9'h1C3 || parityError !== 1'b1)
      $display("[TB] FAIL parity_bad: got data=%h perr=%b expected 1c3/1", rxData, parityError);
    else passCount++;
    ackPulse();
    checkCount++;
    if (parityError !== 1'b0) $display("[TB] FAIL parity_ack_clear: got %b expected 0", parityError);
    else passCount++;
  endtask

  task automatic test_glitch();
    int busySeen = 0;
    clockDivisor = 16; dataBits = 3; parityBit = 0; stopBits2 = 0;
    coe_conduit_rx = 1'b0;
    repeat (4) @(negedge csi_clk);
    coe_conduit_rx = 1'b1;
    repeat (48) begin
      @(negedge csi_clk);
      if (rxBusy) busySeen++;
    end
    checkCount++;
    if (rxFull !== 1'b0 || busySeen != 0)
      $display("[TB] FAIL glitch_rejected: got full=%b busyClocks=%0d expected 0/0", rxFull, busySeen);
    else passCount++;
  endtask

  task automatic test_break();
    int frames = 0;
    logic prevBusy = 1'b0;
    coe_conduit_rx = 1'b0;
    repeat (30 * 16) begin
      @(negedge csi_clk);
      if (rxBusy && !prevBusy) frames++;
      prevBusy = rxBusy;
    end
    coe_conduit_rx = 1'b1;
    repeat (48) begin
      @(negedge csi_clk);
      if (rxBusy && !prevBusy) frames++;
      prevBusy = rxBusy;
    end
    checkCount++;
    if (frames != 1) $display("[TB] FAIL break_frame_count: got %0d expected 1", frames);
    else passCount++;
    checkCount++;
    if (rxData !== 9'h000 || {rxFull, frameError, rxOverRun} !== 3'b110)
      $display("[TB] FAIL break_word: got data=%h full/ferr/ovr=%b expected 000/110",
               rxData, {rxFull, frameError, rxOverRun});
    else passCount++;
    ackPulse();
  endtask

  task automatic test_back_to_back();
    sendFrame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 0);
    sendFrame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 40);
    checkCount++;
    if (rxData !== 9'h022 || rxOverRun !== 1'b1 || rxFull !== 1'b1)
      $display("[TB] FAIL b2b_overrun: got data=%h ovr=%b full=%b expected 022/1/1",
               rxData, rxOverRun, rxFull);
    else passCount++;
    ackPulse();
    checkCount++;
    if (rxFull !== 1'b0 || rxOverRun !== 1'b1)
      $display("[TB] FAIL b2b_ack: got full=%b ovr=%b expected 0/1", rxFull, rxOverRun);
    else passCount++;
  endtask

  task automatic test_reset_mid_frame();
    coe_conduit_rx = 1'b0;
    repeat (48) @(negedge csi_clk);
    checkCount++;
    if (rxBusy !== 1'b1) $display("[TB] FAIL midreset_busy: got %b expected 1", rxBusy);
    else passCount++;
    rsi_reset = 1'b1;
    coe_conduit_rx = 1'b1;
    @(negedge csi_clk);
    checkCount++;
    if ({rxData, rxFull, frameError, parityError, rxOverRun, rxBusy} !== 14'h0)
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {rxData, rxFull, frameError, parityError, rxOverRun, rxBusy});
    else passCount++;
    rsi_reset = 1'b0;
    repeat (40) @(negedge csi_clk);
  endtask

  task automatic test_ack_commit();
    int cnt = 0;
    rxAck = 1'b1;
    fork
      sendFrame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 40);
      begin
        while (!rxBusy && cnt < 300) begin
          @(negedge csi_clk);
          cnt++;
        end
        while (rxBusy && cnt < 600) begin
          @(negedge csi_clk);
          cnt++;
        end
        rxAck = 1'b0;
      end
    join
    checkCount++;
    if (cnt >= 300) $display("[TB] FAIL ackcommit_timeout: got %0d clocks expected < 300", cnt);
    else passCount++;
    checkCount++;
    if (rxData !== 9'h05A || rxFull !== 1'b1 || rxOverRun !== 1'b0)
      $display("[TB] FAIL ackcommit_word: got data=%h full=%b ovr=%b expected 05a/1/0",
               rxData, rxFull, rxOverRun);
    else passCount++;
    ackPulse();
  endtask

  task automatic test_divisor_change();
    clockDivisor = 16; dataBits = 3; parityBit = 0; stopBits2 = 0;
    fork
      sendFrame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 40);
      begin
        repeat (80) @(negedge csi_clk);
        clockDivisor = 32;
      end
    join
    checkCount++;
    if (rxData !== 9'h03C || frameError !== 1'b0)
      $display("[TB] FAIL divchange_old: got data=%h ferr=%b expected 03c/0", rxData, frameError);
    else passCount++;
    ackPulse();
    sendFrame(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32, 72);
    checkCount++;
    if (rxData !== 9'h0C3 || frameError !== 1'b0 || rxFull !== 1'b1)
      $display("[TB] FAIL divchange_new: got data=%h ferr=%b full=%b expected 0c3/0/1",
               rxData, frameError, rxFull);
    else passCount++;
    ackPulse();
  endtask

  task automatic test_random();
    logic [8:0] data, expData;
    logic       pb, stopA, stopB, twoStops, expPar, expFrame;
    int         div, bitClocks, nb, mode;
    for (int n = 0; n < 14; n++) begin
      div       = $urandom_range(20, 0);
      bitClocks = (div < 4) ? 4 : div;
      mode      = $urandom_range(3, 0);
      twoStops  = logic'($urandom_range(1, 0));
      data      = 9'($urandom);
      clockDivisor = 32'(div);
      dataBits     = 3'($urandom_range(7, 0));
      parityBit    = 2'(mode);
      stopBits2    = twoStops;
      nb        = 5 + ((dataBits > 3'd4) ? 4 : int'(dataBits));
      pb        = goodParity(data, nb, mode) ^ ($urandom_range(3, 0) == 0);
      stopA     = ($urandom_range(5, 0) != 0);
      stopB     = ($urandom_range(5, 0) != 0);
      modelFrame(data, nb, mode, pb, stopA, stopB, twoStops, expData, expPar, expFrame);
      sendFrame(data, nb, (mode == 1 || mode == 2), pb, stopA, stopB, twoStops,
                bitClocks, 2 * bitClocks + 8);
      checkCount++;
      if (rxData !== expData || rxFull !== 1'b1 || parityError !== expPar || frameError !== expFrame)
        $display("[TB] FAIL random_%0d: got data=%h full=%b perr=%b ferr=%b expected %h/1/%b/%b (div=%0d nb=%0d mode=%0d)",
                 n, rxData, rxFull, parityError, frameError, expData, expPar, expFrame, div, nb, mode);
      else passCount++;
      ackPulse();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rsi_reset      = 1'b1;
    coe_conduit_rx = 1'b1;
    rxAck          = 1'b0;
    clockDivisor   = 16;
    dataBits       = 3;
    parityBit      = 0;
    stopBits2      = 0;
    @(negedge csi_clk);
    test_reset();
    test_basic();
    test_parity();
    clockDivisor = 16; dataBits = 3; parityBit = 0; stopBits2 = 0;
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_ack_commit();
    test_divisor_change();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
